alimentador_mult8b: RTL and testbench
=====================================

# alimentador_mult8b

Operand feeder and result collector for the 8-bit multiplier `multiplicador8b`. Upstream logic pushes operand pairs through a valid/ready interface into a small FIFO. The block issues each pair to the multiplier with a one-cycle `START` pulse and holds the operands stable until `DONE`. It then presents the 16-bit product on a valid/ready output, in order, one multiplication in flight at a time.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 32: WAIT-state watchdog limit; used only with `MULT_TIMEOUT_EN`.

- `CLK` in 1: single clock; all state updates on posedge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `IN_VALID` in 1: operand pair offered.
- `IN_READY` out 1: FIFO can accept; equals `COUNT < DEPTH`.
- `IN_A`, `IN_B` in 8: operands.
- `OUT_VALID` out 1: result available.
- `OUT_READY` in 1: consumer takes result.
- `OUT_RES` out 16: product.
- `OUT_ERR` out 1: result is a timeout error.
- `MUL_START` out 1: start pulse to the multiplier.
- `MUL_A`, `MUL_B` out 8: operands to the multiplier.
- `MUL_DONE` in 1: multiplier finished.
- `MUL_RES` in 16: multiplier product.
- `BUSY` out 1: FSM not in IDLE.
- `COUNT` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO: circular buffer; read and write pointers wrap modulo `DEPTH`.
  - Push when `IN_VALID && IN_READY`.
  - Push and pop in the same cycle: `COUNT` unchanged.
  - No bypass: a pair is poppable only from the cycle after its push.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when `COUNT>0` and (`!OUT_VALID` or `OUT_READY`). Pops the head into the `MUL_A`/`MUL_B` registers.
  - ISSUE: `MUL_START`=1 for exactly this cycle, then → WAIT. `MUL_DONE` is ignored here.
  - WAIT: on the first cycle `MUL_DONE`=1, load `OUT_RES`←`MUL_RES`, `OUT_ERR`←0, `OUT_VALID`←1, then → IDLE.
  - `MUL_DONE` is ignored in IDLE.
- `MUL_A`/`MUL_B` change only on a pop. They stay stable from ISSUE through the WAIT exit.
- Output register:
  - `OUT_VALID` clears on `OUT_VALID && OUT_READY` unless a new result loads in the same cycle.
  - `OUT_RES`/`OUT_ERR` are stable while `OUT_VALID && !OUT_READY`.
- Results leave in push order.
- Arithmetic: no computation here; `OUT_RES` is `MUL_RES` unmodified. Full range 0..65025.
- Reset values: `OUT_VALID`=0, `OUT_RES`=0, `OUT_ERR`=0, `MUL_START`=0, `MUL_A`=`MUL_B`=0, `BUSY`=0, `COUNT`=0, `IN_READY`=1, FSM=IDLE, pointers=0.
- Reset mid-operation aborts any in-flight multiplication and discards FIFO contents. A `MUL_DONE` arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Pair pushed at edge e0 into an empty FIFO with a free output:
  - e1: pop; enter ISSUE; `MUL_START` high during cycle e1–e2.
  - e2: enter WAIT.
- `MUL_DONE` sampled high at edge ek → `OUT_VALID` high from ek.
- Latency, push to `OUT_VALID` = 2 + multiplier cycles from START to DONE.
- Maximum throughput is one result per (multiplier latency + 2) cycles. No overlap.
- `IN_READY` depends only on `COUNT`, with no combinational path from `OUT_READY`.

## Configuration
- `MULT_TIMEOUT_EN` defined:
  - A cycle counter clears on WAIT entry.
  - If `TIMEOUT_CYCLES` cycles elapse in WAIT without `MUL_DONE`: load `OUT_RES`=16'h0000, `OUT_ERR`=1, `OUT_VALID`=1, → IDLE.
  - If `MUL_DONE` and timeout fall in the same cycle, `MUL_DONE` wins.
- `MULT_TIMEOUT_EN` undefined: WAIT lasts until `MUL_DONE`; `OUT_ERR` is tied 0; no counter logic.

## Test plan
- Reset, push 13×11; model asserts `MUL_DONE` 5 cycles after START → `OUT_VALID` 8 cycles after push edge, `OUT_RES`=16'd143, `OUT_ERR`=0.
- Push 255×255, 0×200, 1×128 back-to-back, `OUT_READY`=1 → `OUT_RES` sequence 16'hFE01, 0, 16'd128, in order, with one `MUL_START` pulse each.
- `OUT_READY`=0, push 6 pairs with DEPTH=4:
  - First result is held; pairs 2–5 fill the FIFO; `COUNT`=4, `IN_READY`=0, pair 6 stalls.
  - Raise `OUT_READY` → all results in order; `IN_READY` returns to 1.
- Hold `OUT_READY`=0 for 10 cycles with a result pending → `OUT_RES`, `OUT_ERR`, `OUT_VALID` unchanged; no new `MUL_START`.
- With `MULT_TIMEOUT_EN`, model never asserts DONE → 32 cycles after WAIT entry `OUT_VALID`=1, `OUT_ERR`=1, `OUT_RES`=0. The next pair 3×4 yields 16'd12, `OUT_ERR`=0.
- Drop `RST_N` during WAIT with 2 pairs queued → immediately `OUT_VALID`=0, `COUNT`=0, `BUSY`=0. A late `MUL_DONE` produces no output.

Source files
------------

// File: rtl/alimentador_mult8b.sv
// Operand FIFO + issue/collect FSM feeding an external 8x8 multiplier, one operation in flight.
// Optional WAIT watchdog enabled by defining MULT_TIMEOUT_EN.
module alimentador_mult8b #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [7:0]              IN_A,
  input  logic [7:0]              IN_B,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [15:0]             OUT_RES,
  output logic                    OUT_ERR,
  output logic                    MUL_START,
  output logic [7:0]              MUL_A,
  output logic [7:0]              MUL_B,
  input  logic                    MUL_DONE,
  input  logic [15:0]             MUL_RES,
  output logic                    BUSY,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic [1:0]              DBG_STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("alimentador_mult8b: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic          push, pop, load_ok, load_err;
  logic          out_valid;
  logic [15:0]   out_res;

  // Both ports use valid/ready: a transfer happens on a rising CLK edge where
  // valid and ready are both high; valid never waits on ready, and IN_READY is
  // a function of the registered occupancy only.
  assign IN_READY  = (count < FULL);
  assign push      = IN_VALID && IN_READY;
  assign pop       = (state == S_IDLE) && (count != '0) && (!out_valid || OUT_READY);
  assign load_ok   = (state == S_WAIT) && MUL_DONE;

  assign OUT_VALID = out_valid;
  assign OUT_RES   = out_res;
  assign MUL_START = (state == S_ISSUE);
  assign BUSY      = (state != S_IDLE);
  assign COUNT     = count;
  assign DBG_STATE = state;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {IN_A, IN_B};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= S_IDLE;
      MUL_A     <= '0;
      MUL_B     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        {MUL_A, MUL_B} <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        S_IDLE:  if (pop) state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (load_ok || load_err) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A fresh result takes priority over the consumer draining the old one.
      if (load_ok) begin
        out_valid <= 1'b1;
        out_res   <= MUL_RES;
      end else if (load_err) begin
        out_valid <= 1'b1;
        out_res   <= '0;
      end else if (out_valid && OUT_READY) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] wait_cnt;
  logic          out_err;

  // MUL_DONE wins over an expiring watchdog in the same cycle.
  assign load_err = (state == S_WAIT) && !MUL_DONE && (wait_cnt == TO_LAST);
  assign OUT_ERR  = out_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      out_err  <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + TO_ONE;
      if (load_ok)       out_err <= 1'b0;
      else if (load_err) out_err <= 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
  assign OUT_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_alimentador_mult8b.sv
// Randomised and directed bench for alimentador_mult8b with a behavioural multiplier and result scoreboard.
module tb_alimentador_mult8b;

  localparam int DEPTH = 4;

  logic        CLK, RST_N;
  logic        IN_VALID, IN_READY;
  logic [7:0]  IN_A, IN_B;
  logic        OUT_VALID, OUT_READY, OUT_ERR;
  logic [15:0] OUT_RES;
  logic        MUL_START, MUL_DONE, BUSY;
  logic [7:0]  MUL_A, MUL_B;
  logic [15:0] MUL_RES;
  logic [2:0]  COUNT;
  logic [1:0]  DBG_STATE;

  alimentador_mult8b #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RES(OUT_RES), .OUT_ERR(OUT_ERR),
    .MUL_START(MUL_START), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_DONE(MUL_DONE), .MUL_RES(MUL_RES),
    .BUSY(BUSY), .COUNT(COUNT), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  int mul_lat = 5;
  bit mul_hang = 0;
  bit rand_lat = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier model ----------------
  initial begin
    logic [7:0] ma, mb;
    int lat;
    MUL_DONE = 1'b0;
    MUL_RES  = '0;
    forever begin
      @(negedge CLK); #1;
      if (RST_N && MUL_START) begin
        ma  = MUL_A;
        mb  = MUL_B;
        lat = rand_lat ? int'($urandom_range(0, 6)) : mul_lat;
        if (!mul_hang) begin
          repeat (lat + 1) @(posedge CLK);
          #1;
          MUL_DONE = 1'b1;
          MUL_RES  = {8'd0, ma} * {8'd0, mb};
          @(posedge CLK); #1;
          MUL_DONE = 1'b0;
          MUL_RES  = 16'($urandom);
        end
      end
    end
  end

  always begin
    @(negedge CLK); #1;
    if (MUL_START) start_cnt++;
  end

  always begin
    @(negedge CLK);
    if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  always begin
    @(negedge CLK); #1;
    if (RST_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL result_unexpected: got 0x%0h expected none at %0t", {OUT_ERR, OUT_RES}, $time);
      end else begin
        check("result", 32'({OUT_ERR, OUT_RES}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit to_err);
    bit rdy;
    int waited = 0;
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_A = a;
    IN_B = b;
    forever begin
      #1 rdy = IN_READY;
      @(posedge CLK);
      if (rdy) begin
        exp_q.push_back(to_err ? 17'h10000 : {1'b0, {8'd0, a} * {8'd0, b}});
        break;
      end
      @(negedge CLK);
      waited++;
      if (waited > 300) begin
        check("push_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    #1 IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while (!OUT_VALID && n < 300);
    if (!OUT_VALID) check("wait_valid_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && !BUSY && COUNT == 0 && !OUT_VALID) && n < 2000) begin
      @(negedge CLK); #1;
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, s0;
    IN_VALID = 0; IN_A = 0; IN_B = 0; OUT_READY = 1;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_flags", 32'({OUT_VALID, OUT_ERR, MUL_START, BUSY, IN_READY}), 32'b00001);
    check("rst_out_res", 32'(OUT_RES), 32'd0);
    check("rst_mul_ops", 32'({MUL_A, MUL_B}), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    @(negedge CLK) RST_N = 1'b1;

    // 13 x 11 with DONE five cycles after START is seen
    mul_lat = 5;
    push(8'd13, 8'd11, 1'b0);
    wait_valid(n);
    check("latency", 32'(n - 1), 32'd8);
    check("first_res", 32'({OUT_ERR, OUT_RES}), 32'd143);
    wait_idle();

    // back-to-back extremes
    s0 = start_cnt;
    push(8'd255, 8'd255, 1'b0);
    push(8'd0, 8'd200, 1'b0);
    push(8'd1, 8'd128, 1'b0);
    wait_idle();
    check("starts_b2b", 32'(start_cnt - s0), 32'd3);

    // back-pressure: first result held, FIFO fills, sixth pair stalls
    mul_lat = 3;
    @(negedge CLK) OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom), 1'b0);
    wait_valid(n);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      check("hold_out", 32'({OUT_VALID, OUT_ERR, OUT_RES}), 32'({1'b1, exp_q[0]}));
    end
    check("hold_no_start", 32'(start_cnt - s0), 32'd0);
    check("full_count", 32'(COUNT), 32'd4);
    check("full_in_ready", 32'(IN_READY), 32'd0);
    fork
      push(8'($urandom), 8'($urandom), 1'b0);
      begin
        repeat (4) @(negedge CLK);
        #1 check("stall_in_ready", 32'({IN_READY, COUNT}), 32'({1'b0, 3'd4}));
        @(negedge CLK) OUT_READY = 1'b1;
      end
    join
    wait_idle();
    check("drain_in_ready", 32'(IN_READY), 32'd1);

`ifdef MULT_TIMEOUT_EN
    mul_hang = 1;
    push(8'd7, 8'd9, 1'b1);
    wait_valid(n);
    check("timeout_latency", 32'(n - 1), 32'd34);
    wait_idle();
    mul_hang = 0;
    push(8'd3, 8'd4, 1'b0);
    wait_idle();
`endif

    // randomised traffic with random latency and consumer stalls
    rand_lat = 1;
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       push(8'hFF, 8'($urandom), 1'b0);
        1:       push(8'h00, 8'($urandom), 1'b0);
        default: push(8'($urandom), 8'($urandom), 1'b0);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    rand_ready = 0;
    rand_lat = 0;
    @(negedge CLK) OUT_READY = 1'b1;
    wait_idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // reset during WAIT with two pairs queued; the late DONE must be ignored
    mul_lat = 20;
    push(8'd21, 8'd2, 1'b0);
    push(8'd5, 8'd6, 1'b0);
    push(8'd9, 8'd9, 1'b0);
    repeat (3) @(negedge CLK);
    #1 check("pre_rst_state", 32'({BUSY, COUNT}), 32'({1'b1, 3'd2}));
    @(negedge CLK) RST_N = 1'b0;
    #1;
    check("mid_rst_flags", 32'({OUT_VALID, BUSY, IN_READY}), 32'b001);
    check("mid_rst_count", 32'(COUNT), 32'd0);
    exp_q.delete();
    @(negedge CLK) RST_N = 1'b1;
    s0 = start_cnt;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK); #1;
      if (OUT_VALID || BUSY) n++;
    end
    check("late_done_ignored", 32'(n), 32'd0);
    check("late_no_start", 32'(start_cnt - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
